// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: 32xDW register file, EX/MEM/WB forwarding, hazard stall, ID/EX register.
// Define OPFETCH_FORWARD_EN for full forwarding (load-use stalls only); otherwise only the WB bypass exists.
module id_opf_src #(
  parameter int DW = 32
) (
  input  logic [4:0]    i_n,
  input  logic          i_used,
  input  logic          i_ex_we,
  input  logic [4:0]    i_ex_waddr,
  input  logic [DW-1:0] i_ex_wdata,
  input  logic          i_mem_we,
  input  logic [4:0]    i_mem_waddr,
  input  logic [DW-1:0] i_mem_wdata,
  input  logic          i_wb_we,
  input  logic [4:0]    i_wb_waddr,
  input  logic [DW-1:0] i_wb_wdata,
  input  logic [DW-1:0] i_rf_rd,
  output logic [DW-1:0] o_val,
  output logic          o_ex_hit,
  output logic          o_mem_hit
);
  logic w_nz, w_wb_hit;

  assign w_nz      = (i_n != 5'd0);
  assign o_ex_hit  = i_used & w_nz & i_ex_we  & (i_ex_waddr  == i_n);
  assign o_mem_hit = i_used & w_nz & i_mem_we & (i_mem_waddr == i_n);
  assign w_wb_hit  = i_used & w_nz & i_wb_we  & (i_wb_waddr  == i_n);

`ifdef OPFETCH_FORWARD_EN
  // Youngest producer wins.
  always_comb begin
    o_val = i_rf_rd;
    if (!w_nz)          o_val = '0;
    else if (o_ex_hit)  o_val = i_ex_wdata;
    else if (o_mem_hit) o_val = i_mem_wdata;
    else if (w_wb_hit)  o_val = i_wb_wdata;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_ex_wdata, i_mem_wdata};

  always_comb begin
    o_val = i_rf_rd;
    if (!w_nz)         o_val = '0;
    else if (w_wb_hit) o_val = i_wb_wdata;
  end
`endif
endmodule

module id_operand_fetch #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    r1,
  input  logic [4:0]    r2,
  input  logic          r1_used,
  input  logic          r2_used,
  input  logic          id_valid,
  input  logic          flush,
  input  logic          ex_hold,
  input  logic          ex_we,
  input  logic [4:0]    ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          ex_is_load,
  input  logic          mem_we,
  input  logic [4:0]    mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          wb_we,
  input  logic [4:0]    wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic          stall_id,
  output logic          ex_valid,
  output logic [4:0]    ex_r1,
  output logic [4:0]    ex_r2,
  output logic [DW-1:0] ex_rv1,
  output logic [DW-1:0] ex_rv2
);
  localparam int NSRC = 2;

  logic [DW-1:0] r_rf [32];

  logic [NSRC-1:0][4:0]    w_n;
  logic [NSRC-1:0]         w_used;
  logic [NSRC-1:0][DW-1:0] w_val;
  logic [NSRC-1:0]         w_ex_hit;
  logic [NSRC-1:0]         w_mem_hit;
  logic                    w_stall;

  assign w_n    = {r2, r1};
  assign w_used = {r2_used, r1_used};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    id_opf_src #(.DW(DW)) u_src (
      .i_n        (w_n[g]),
      .i_used     (w_used[g]),
      .i_ex_we    (ex_we),
      .i_ex_waddr (ex_waddr),
      .i_ex_wdata (ex_wdata),
      .i_mem_we   (mem_we),
      .i_mem_waddr(mem_waddr),
      .i_mem_wdata(mem_wdata),
      .i_wb_we    (wb_we),
      .i_wb_waddr (wb_waddr),
      .i_wb_wdata (wb_wdata),
      .i_rf_rd    (r_rf[w_n[g]]),
      .o_val      (w_val[g]),
      .o_ex_hit   (w_ex_hit[g]),
      .o_mem_hit  (w_mem_hit[g])
    );
  end

`ifdef OPFETCH_FORWARD_EN
  logic w_unused_mem;
  assign w_unused_mem = |w_mem_hit;
  // Hits already require a nonzero source, so ex_waddr != 0 is implied.
  assign w_stall = id_valid & ex_is_load & (|w_ex_hit);
`else
  logic w_unused_ld;
  assign w_unused_ld = ex_is_load;
  assign w_stall = id_valid & ((|w_ex_hit) | (|w_mem_hit));
`endif

  assign stall_id = w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_we && wb_waddr != 5'd0) begin
      r_rf[wb_waddr] <= wb_wdata;
    end
  end

  logic          r_ex_valid;
  logic [4:0]    r_ex_r1, r_ex_r2;
  logic [DW-1:0] r_ex_rv1, r_ex_rv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_r1    <= '0;
      r_ex_r2    <= '0;
      r_ex_rv1   <= '0;
      r_ex_rv2   <= '0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (ex_hold) begin
      r_ex_valid <= r_ex_valid;
    end else if (w_stall) begin
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid <= id_valid;
      r_ex_r1    <= r1;
      r_ex_r2    <= r2;
      r_ex_rv1   <= w_val[0];
      r_ex_rv2   <= w_val[1];
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_r1    = r_ex_r1;
  assign ex_r2    = r_ex_r2;
  assign ex_rv1   = r_ex_rv1;
  assign ex_rv2   = r_ex_rv2;
endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch; expectations follow OPFETCH_FORWARD_EN when defined.
module tb_id_operand_fetch;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    r1, r2;
  logic          r1_used, r2_used, id_valid, flush, ex_hold;
  logic          ex_we, ex_is_load, mem_we, wb_we;
  logic [4:0]    ex_waddr, mem_waddr, wb_waddr;
  logic [DW-1:0] ex_wdata, mem_wdata, wb_wdata;
  logic          stall_id, ex_valid;
  logic [4:0]    ex_r1, ex_r2;
  logic [DW-1:0] ex_rv1, ex_rv2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_operand_fetch #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .r1_used(r1_used), .r2_used(r2_used),
    .id_valid(id_valid), .flush(flush), .ex_hold(ex_hold),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_r1(ex_r1), .ex_r2(ex_r2),
    .ex_rv1(ex_rv1), .ex_rv2(ex_rv2)
  );

  task automatic idle();
    rst = 0; r1 = 0; r2 = 0; r1_used = 0; r2_used = 0; id_valid = 0; flush = 0; ex_hold = 0;
    ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 0;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
    checks++; if ({ex_r1, ex_r2} !== 10'd0) begin failures++; $display("FAIL reset_regs got=%0h exp=0", {ex_r1, ex_r2}); end
    checks++; if ({ex_rv1, ex_rv2} !== 64'd0) begin failures++; $display("FAIL reset_vals got=%0h exp=0", {ex_rv1, ex_rv2}); end
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_id); end
    rst = 0;
  endtask

  task automatic test_wb_bypass();
    idle();
    wb_we = 1; wb_waddr = 5; wb_wdata = 32'h1234;
    id_valid = 1; r1 = 5; r1_used = 1; r2 = 0; r2_used = 1;
    step();
    checks++; if (ex_rv1 !== 32'h1234) begin failures++; $display("FAIL wb_bypass_rv1 got=%0h exp=1234", ex_rv1); end
    checks++; if (ex_valid !== 1'b1 || ex_r1 !== 5'd5) begin failures++; $display("FAIL wb_bypass_ctl got=%0h/%0d exp=1/5", ex_valid, ex_r1); end
    checks++; if (ex_rv2 !== 32'h0) begin failures++; $display("FAIL wb_bypass_rv2 got=%0h exp=0", ex_rv2); end
    wb_we = 0; wb_wdata = 0;
    step();
    checks++; if (ex_rv1 !== 32'h1234) begin failures++; $display("FAIL rf_read got=%0h exp=1234", ex_rv1); end
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFF; r1 = 0;
    step();
    checks++; if (ex_rv1 !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%0h exp=0", ex_rv1); end
    wb_we = 0;
    step();
    checks++; if (ex_rv1 !== 32'h0) begin failures++; $display("FAIL r0_array got=%0h exp=0", ex_rv1); end
  endtask

  task automatic test_fwd_priority();
    idle();
    ex_we = 1; ex_waddr = 3; ex_wdata = 32'hA;
    mem_we = 1; mem_waddr = 3; mem_wdata = 32'hB;
    wb_we = 1; wb_waddr = 3; wb_wdata = 32'hC;
    id_valid = 1; r2 = 3; r2_used = 1;
    #1;
`ifdef OPFETCH_FORWARD_EN
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL prio_stall got=%0h exp=0", stall_id); end
    step();
    checks++; if (ex_rv2 !== 32'hA || ex_valid !== 1'b1) begin failures++; $display("FAIL prio_ex got=%0h/%0h exp=a/1", ex_rv2, ex_valid); end
`else
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL prio_stall got=%0h exp=1", stall_id); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL prio_bubble got=%0h exp=0", ex_valid); end
`endif
    ex_we = 0; wb_we = 0;
    #1;
`ifdef OPFETCH_FORWARD_EN
    step();
    checks++; if (ex_rv2 !== 32'hB || ex_valid !== 1'b1) begin failures++; $display("FAIL mem_fwd got=%0h/%0h exp=b/1", ex_rv2, ex_valid); end
`else
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL mem_stall got=%0h exp=1", stall_id); end
    step();
`endif
    mem_we = 0; wb_we = 1; wb_wdata = 32'hD;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL wb_nostall got=%0h exp=0", stall_id); end
    step();
    checks++; if (ex_rv2 !== 32'hD || ex_valid !== 1'b1) begin failures++; $display("FAIL wb_fwd got=%0h/%0h exp=d/1", ex_rv2, ex_valid); end
    wb_we = 0;
  endtask

  task automatic test_load_use();
    idle();
    ex_we = 1; ex_waddr = 7; ex_wdata = 32'hDEAD; ex_is_load = 1;
    id_valid = 1; r1 = 7; r1_used = 1;
    #1;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0h exp=1", stall_id); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0h exp=0", ex_valid); end
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_waddr = 7; mem_wdata = 32'h55;
    #1;
`ifdef OPFETCH_FORWARD_EN
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_release got=%0h exp=0", stall_id); end
    step();
`else
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL lu_mem_stall got=%0h exp=1", stall_id); end
    step();
    mem_we = 0; wb_we = 1; wb_waddr = 7; wb_wdata = 32'h55;
    step();
    wb_we = 0;
`endif
    checks++; if (ex_rv1 !== 32'h55 || ex_valid !== 1'b1) begin failures++; $display("FAIL lu_value got=%0h/%0h exp=55/1", ex_rv1, ex_valid); end
    mem_we = 0;
    ex_we = 1; ex_waddr = 7; ex_is_load = 1; r1_used = 0;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL unused_stall got=%0h exp=0", stall_id); end
    step();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL unused_valid got=%0h exp=1", ex_valid); end
  endtask

  task automatic test_hold_flush();
    idle();
    id_valid = 1; r1 = 5; r1_used = 1; r2 = 3; r2_used = 1;
    step();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      r1 = 5'(i + 10); r2 = 5'(i + 20); id_valid = i[0];
      step();
    end
    checks++; if (ex_r1 !== 5'd5 || ex_r2 !== 5'd3) begin failures++; $display("FAIL hold_regs got=%0d/%0d exp=5/3", ex_r1, ex_r2); end
    checks++; if (ex_rv1 !== 32'h1234 || ex_rv2 !== 32'hD) begin failures++; $display("FAIL hold_vals got=%0h/%0h exp=1234/d", ex_rv1, ex_rv2); end
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%0h exp=1", ex_valid); end
    flush = 1;
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_hold got=%0h exp=0", ex_valid); end
    ex_hold = 0; id_valid = 1; r1 = 7; r1_used = 1;
    ex_we = 1; ex_waddr = 7; ex_is_load = 1;
    #1;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL flush_stall got=%0h exp=1", stall_id); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%0h exp=0", ex_valid); end
  endtask

  task automatic test_reset_mid();
    idle();
    wb_we = 1; wb_waddr = 9; wb_wdata = 32'h99;
    id_valid = 1; r1 = 5; r1_used = 1;
    step();
    wb_we = 0; r1 = 9; r2 = 5; r2_used = 1;
    step();
    checks++; if (ex_rv1 !== 32'h99 || ex_rv2 !== 32'h1234) begin failures++; $display("FAIL pre_rst got=%0h/%0h exp=99/1234", ex_rv1, ex_rv2); end
    rst = 1;
    step();
    checks++; if ({ex_valid, ex_r1, ex_r2} !== 11'd0 || {ex_rv1, ex_rv2} !== 64'd0) begin failures++; $display("FAIL mid_rst got=%0h %0h exp=0 0", {ex_valid, ex_r1, ex_r2}, {ex_rv1, ex_rv2}); end
    rst = 0;
    step();
    checks++; if (ex_rv1 !== 32'h0 || ex_rv2 !== 32'h0 || ex_valid !== 1'b1) begin failures++; $display("FAIL post_rst got=%0h/%0h/%0h exp=0/0/1", ex_rv1, ex_rv2, ex_valid); end
  endtask

  initial begin
    idle();
    test_reset();
    test_wb_bypass();
    test_fwd_priority();
    test_load_use();
    test_hold_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
